layer_cnu: RTL and testbench

Serial offset-min-sum check-node unit for the layered QC-LDPC decoder. It sits directly downstream of the permuter and consumes one cyclically shifted Z-lane block of variable-to-check messages per beat for the current layer. After the row's last block it emits one check-to-variable block per participating column, in arrival order. It processes Z independent check rows in parallel lanes, one layer row-group at a time.

---
 rtl/layer_cnu.sv | 132 +++++++++++++
 tb/tb_layer_cnu.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_cnu.sv
// Serial offset-min-sum check-node unit: accumulates per-lane min1/min2/idx/sign
// over one layer row, then streams one check-to-variable block per column.
module layer_cnu #(
  parameter int BITS     = 8,
  parameter int Z        = 32,
  parameter int DMAX     = 6,
  parameter int OFFSET   = 1,
  parameter int IDX_BITS = $clog2(DMAX)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [Z-1:0][BITS-1:0]     in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [IDX_BITS-1:0]        out_idx,
  output logic [Z-1:0][BITS-1:0]     out_data,
  output logic                       deg_err
);

  typedef enum logic {ACC, EMIT} state_t;

  localparam logic [BITS-2:0]     MAXM  = '1;
  localparam logic [BITS-2:0]     OFF   = (BITS-1)'(OFFSET);
  localparam logic [IDX_BITS-1:0] K_MAX = IDX_BITS'(DMAX-1);

  state_t              state, state_next;
  logic [IDX_BITS-1:0] k, j, last_j;
  logic                in_fire, out_fire, end_row, emit_done;

  logic [BITS-2:0]     min1 [Z];
  logic [BITS-2:0]     min2 [Z];
  logic [IDX_BITS-1:0] idx  [Z];
  logic [Z-1:0]        sgn;
  logic [Z-1:0]        sign_mem [DMAX];
  logic [BITS-2:0]     mag  [Z];

  // Magnitude with the most-negative code saturated to MAXM.
  always_comb begin
    for (int l = 0; l < Z; l++) begin
      if (!in_data[l][BITS-1])             mag[l] = in_data[l][BITS-2:0];
      else if (in_data[l][BITS-2:0] == '0) mag[l] = MAXM;
      else                                 mag[l] = ~in_data[l][BITS-2:0] + 1'b1;
    end
  end

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    in_ready   = (state == ACC);
    out_valid  = (state == EMIT);
    in_fire    = in_valid && in_ready;
    out_fire   = out_valid && out_ready;
    end_row    = in_fire && (in_last || k == K_MAX);
    emit_done  = out_fire && (j == last_j);
    case (state)
      ACC:     if (end_row)   state_next = EMIT;
      EMIT:    if (emit_done) state_next = ACC;
      default: state_next = ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACC;
      k       <= '0;
      j       <= '0;
      last_j  <= '0;
      deg_err <= 1'b0;
    end else begin
      state <= state_next;
      if (end_row) begin
        last_j <= k;
        k      <= '0;
        j      <= '0;
        if (!in_last) deg_err <= 1'b1;
      end else if (in_fire) begin
        k <= k + 1'b1;
      end
      if (out_fire) j <= emit_done ? '0 : j + 1'b1;
    end
  end

  // NOTE: the row datapath is not reset; k==0 reinitialises it on the first beat of every row.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int l = 0; l < Z; l++) begin
        sign_mem[k][l] <= in_data[l][BITS-1];
        if (k == '0) begin
          min1[l] <= mag[l];
          min2[l] <= MAXM;
          idx[l]  <= '0;
          sgn[l]  <= in_data[l][BITS-1];
        end else begin
          sgn[l] <= sgn[l] ^ in_data[l][BITS-1];
          if (mag[l] < min1[l]) begin
            min2[l] <= min1[l];
            min1[l] <= mag[l];
            idx[l]  <= k;
          end else if (mag[l] < min2[l]) begin
            min2[l] <= mag[l];
          end
        end
      end
    end
  end

  function automatic logic [BITS-1:0] c2v(input logic [BITS-2:0] sel, input logic neg);
    logic [BITS-2:0] m;
    logic [BITS-1:0] v;
    m = (sel > OFF) ? sel - OFF : '0;
    v = {1'b0, m};
    return neg ? -v : v;
  endfunction

  always_comb begin
    out_data = '0;
    out_idx  = '0;
    out_last = 1'b0;
    if (out_valid) begin
      out_idx  = j;
      out_last = (j == last_j);
      for (int l = 0; l < Z; l++)
        out_data[l] = c2v((j == idx[l]) ? min2[l] : min1[l], sgn[l] ^ sign_mem[j][l]);
    end
  end

endmodule

// File: tb/tb_layer_cnu.sv
// Randomized bench for layer_cnu; expected messages come from an extrinsic-minimum
// reference model (min and sign product over all other columns of the row).
module tb_layer_cnu;
  localparam int BITS = 8, Z = 32, DMAX = 6, OFFSET = 1, IDX_BITS = 3;
  localparam int MAXM = 2**(BITS-1) - 1;

  logic clk = 1'b0, rst_n;
  logic in_valid, in_ready, in_last, out_valid, out_ready, out_last, deg_err;
  logic [Z-1:0][BITS-1:0] in_data, out_data;
  logic [IDX_BITS-1:0]    out_idx;

  int n_checks = 0, n_pass = 0;
  logic signed [BITS-1:0] row [DMAX][Z];
  int  exp0 [DMAX];
  bit  use0;

  always #5 clk = ~clk;

  layer_cnu #(.BITS(BITS), .Z(Z), .DMAX(DMAX), .OFFSET(OFFSET)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_idx(out_idx), .out_data(out_data), .deg_err(deg_err));

  task automatic check(input string tag, input logic [Z*BITS-1:0] got, input logic [Z*BITS-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [Z-1:0][BITS-1:0] beat(input int i);
    logic [Z-1:0][BITS-1:0] r;
    for (int l = 0; l < Z; l++) r[l] = row[i][l];
    return r;
  endfunction

  // Check-to-variable message for column j: min |q| and sign parity over columns i != j.
  function automatic logic [Z-1:0][BITS-1:0] model_out(input int j, input int n);
    logic [Z-1:0][BITS-1:0] r;
    for (int l = 0; l < Z; l++) begin
      int m = MAXM, neg = 0, v, a, o;
      for (int i = 0; i < n; i++) begin
        if (i == j) continue;
        v = row[i][l];
        a = (v < 0) ? ((v == -(MAXM+1)) ? MAXM : -v) : v;
        if (a < m) m = a;
        if (v < 0) neg ^= 1;
      end
      m = (m - OFFSET < 0) ? 0 : m - OFFSET;
      o = neg ? -m : m;
      r[l] = o[BITS-1:0];
    end
    return r;
  endfunction

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++)
      for (int l = 0; l < Z; l++) row[i][l] = BITS'($urandom);
  endtask

  task automatic set_lane0(input int i, input int v, input int e);
    row[i][0] = v[BITS-1:0];
    exp0[i]   = e;
  endtask

  task automatic send_row(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = beat(i);
      in_last  = with_last && (i == n-1);
      check("in_ready_acc", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    check("latency_out_valid", out_valid, 1);
  endtask

  task automatic recv_beats(input int from, input int upto, input int n, input bit stall);
    int j = from, cyc = 0;
    logic [BITS-1:0] e;
    while (j < upto && cyc < 200) begin
      out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      check("out_valid", out_valid, 1);
      check("in_ready_emit", in_ready, 0);
      check("out_idx", out_idx, j[IDX_BITS-1:0]);
      check("out_last", out_last, j == n-1);
      check("out_data", out_data, model_out(j, n));
      if (use0) begin
        e = exp0[j][BITS-1:0];
        check("lane0", out_data[0], e);
      end
      @(posedge clk); #1;
      if (out_ready) j++;
      cyc++;
    end
    if (j < upto) check("recv_timeout", 0, 1);
    out_ready = 1'b1;
  endtask

  task automatic check_idle();
    check("idle_out_valid", out_valid, 0);
    check("idle_out_data", out_data, 0);
    check("idle_out_idx", out_idx, 0);
    check("idle_out_last", out_last, 0);
    check("idle_in_ready", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1; use0 = 0;
    #23;
    check_idle();
    check("reset_deg_err", deg_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Degree-4 row: lane 0 carries +5,-3,+7,-2.
    fill_random(4);
    set_lane0(0, 5, 1); set_lane0(1, -3, -1); set_lane0(2, 7, 1); set_lane0(3, -2, -2);
    use0 = 1;
    send_row(4, 1);
    recv_beats(0, 4, 4, 0);
    check_idle();

    // Saturation and tie.
    fill_random(3);
    set_lane0(0, -128, 3); set_lane0(1, 4, -3); set_lane0(2, 4, -3);
    send_row(3, 1);
    recv_beats(0, 3, 3, 0);
    check_idle();

    // Offset floor and zero sign.
    fill_random(3);
    set_lane0(0, 0, 0); set_lane0(1, -1, 0); set_lane0(2, 9, 0);
    send_row(3, 1);
    recv_beats(0, 3, 3, 0);

    // Degree 1.
    fill_random(1);
    set_lane0(0, 5, 126);
    send_row(1, 1);
    recv_beats(0, 1, 1, 0);
    check_idle();
    use0 = 0;

    // Backpressure at j=1 with ignored in_valid pulses.
    fill_random(4);
    send_row(4, 1);
    recv_beats(0, 1, 4, 0);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_last = 1'b1; in_data = {Z{BITS'($urandom)}};
      check("bp_in_ready", in_ready, 0);
      check("bp_out_idx", out_idx, 1);
      check("bp_out_data", out_data, model_out(1, 4));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    recv_beats(1, 4, 4, 0);
    check_idle();

    // Exact-dmax row with in_last is normal termination.
    fill_random(DMAX);
    send_row(DMAX, 1);
    check("dmax_last_deg_err", deg_err, 0);
    recv_beats(0, DMAX, DMAX, 0);

    // Degree overflow, then a well-formed row.
    fill_random(DMAX);
    send_row(DMAX, 0);
    check("overflow_deg_err", deg_err, 1);
    recv_beats(0, DMAX, DMAX, 0);
    check_idle();
    fill_random(3);
    send_row(3, 1);
    recv_beats(0, 3, 3, 0);
    check("sticky_deg_err", deg_err, 1);

    // Reset mid-EMIT.
    fill_random(4);
    send_row(4, 1);
    recv_beats(0, 2, 4, 0);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_deg_err", deg_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    fill_random(4);
    set_lane0(0, 5, 1); set_lane0(1, -3, -1); set_lane0(2, 7, 1); set_lane0(3, -2, -2);
    use0 = 1;
    send_row(4, 1);
    recv_beats(0, 4, 4, 0);
    use0 = 0;

    // Random rows with random output stalls.
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, DMAX);
      fill_random(n);
      send_row(n, 1);
      recv_beats(0, n, n, 1);
      check_idle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
